// File: rtl/i2c_bus_conditioner.sv
// -----------------------------------------------------------------------------
// i2c_bus_conditioner
// Pad-side stage between the I2C handler and the open-drain SCL/SDA pins.
//  - Synchronises and deglitches the raw SDA pad level per channel.
//  - Flags channels whose SDA is held low while SCL is released (sticky).
//  - Runs a CSR-commanded bus-recovery sequence on one channel:
//    up to 9 SCL pulses, then a STOP condition.
//  - On every channel not under recovery, handler drive passes to the pins
//    with one cycle of latency.
// Ports
//  clk, rst         system clock, asynchronous active-high reset
//  csrStrobe        GPIO_OUT holds a command this cycle
//  GPIO_OUT         [31] start recovery, [30] clear flags, [2:0] channel
//  status           [31] busy, [30] fail, [29] done, [27:24] pulse count,
//                   [22:20] channel, [15:8] stuck flags, [7:0] filtered SDA
//  scl_in           handler SCL (0 = pull low)
//  sda_drive_in     handler SDA drive (0 = pull low)
//  sda_sense_out    filtered SDA returned to the handler
//  scl_pin, sda_pin pad drive, 0 = drive low, 1 = release
//  sda_pin_sense    raw asynchronous SDA level from the pad
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_bus_conditioner #(
    parameter int CLK_RATE      = 100000000,
    parameter int I2C_RATE      = 100000,
    parameter int CHANNEL_COUNT = 4,
    parameter int FILTER_LEN    = 4,
    parameter int STUCK_CYCLES  = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     csrStrobe,
    input  logic [31:0]              GPIO_OUT,
    output logic [31:0]              status,
    input  logic [CHANNEL_COUNT-1:0] scl_in,
    input  logic [CHANNEL_COUNT-1:0] sda_drive_in,
    output logic [CHANNEL_COUNT-1:0] sda_sense_out,
    output logic [CHANNEL_COUNT-1:0] scl_pin,
    output logic [CHANNEL_COUNT-1:0] sda_pin,
    input  logic [CHANNEL_COUNT-1:0] sda_pin_sense
);

    localparam int HALF = CLK_RATE / (2 * I2C_RATE);
    localparam int TW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int SW   = $clog2(STUCK_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOW, ST_HIGH, ST_STOP_LOW, ST_STOP_SETUP, ST_STOP_HIGH
    } state_t;

    logic [CHANNEL_COUNT-1:0] sync1_r, sync2_r, sense_r;
    logic [3:0]               run_r [CHANNEL_COUNT];
    logic [SW-1:0]            stuck_cnt_r [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0] stuck_r;
    state_t                   state_r, state_s;
    logic [TW-1:0]            timer_r;
    logic [3:0]               pulse_r;
    logic [2:0]               chan_r, chan_sel_s;
    logic                     done_r, fail_r, busy_r;
    logic [CHANNEL_COUNT-1:0] scl_pin_r, sda_pin_r, scl_next_s, sda_next_s;
    logic                     start_s, clear_s, timer_last_s, sel_sense_s;
    logic                     pulse_inc_s, set_fail_s, set_done_s;
    logic                     rec_scl_s, rec_sda_s;
    logic [7:0]               stuck_byte_s, sense_byte_s;
    logic                     gpio_unused_s;

    assign gpio_unused_s = ^GPIO_OUT[29:3];

    // Start is honoured only from IDLE and for an existing channel.
    assign start_s      = csrStrobe & GPIO_OUT[31] & (state_r == ST_IDLE) &
                          ({1'b0, GPIO_OUT[2:0]} < 4'(CHANNEL_COUNT));
    assign clear_s      = csrStrobe & GPIO_OUT[30];
    assign timer_last_s = (timer_r == TW'(HALF - 1));

    // SDA synchroniser and run-length deglitch filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= {CHANNEL_COUNT{1'b1}};
            sync2_r <= {CHANNEL_COUNT{1'b1}};
            sense_r <= {CHANNEL_COUNT{1'b1}};
            for (int i = 0; i < CHANNEL_COUNT; i++) run_r[i] <= 4'd0;
        end else begin
            sync1_r <= sda_pin_sense;
            sync2_r <= sync1_r;
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                if (sync2_r[i] != sense_r[i]) begin
                    if (run_r[i] == 4'(FILTER_LEN - 1)) begin
                        sense_r[i] <= sync2_r[i];
                        run_r[i]   <= 4'd0;
                    end else begin
                        run_r[i] <= run_r[i] + 4'd1;
                    end
                end else begin
                    run_r[i] <= 4'd0;
                end
            end
        end
    end

    // Stuck-low counters and sticky flags; a set in the same cycle beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck_r <= {CHANNEL_COUNT{1'b0}};
            for (int i = 0; i < CHANNEL_COUNT; i++) stuck_cnt_r[i] <= {SW{1'b0}};
        end else begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                if (!sense_r[i] && scl_in[i]) begin
                    if (stuck_cnt_r[i] != SW'(STUCK_CYCLES)) begin
                        stuck_cnt_r[i] <= stuck_cnt_r[i] + SW'(1'b1);
                    end else begin
                        stuck_cnt_r[i] <= stuck_cnt_r[i];
                    end
                end else begin
                    stuck_cnt_r[i] <= {SW{1'b0}};
                end
                // Count reaches STUCK_CYCLES on this edge when it is one below now.
                if (!sense_r[i] && scl_in[i] && (stuck_cnt_r[i] >= SW'(STUCK_CYCLES - 1))) begin
                    stuck_r[i] <= 1'b1;
                end else if (clear_s) begin
                    stuck_r[i] <= 1'b0;
                end else begin
                    stuck_r[i] <= stuck_r[i];
                end
            end
        end
    end

    // Filtered SDA of the channel under recovery.
    always_comb begin
        sel_sense_s = 1'b1;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            sel_sense_s = (chan_r == 3'(i)) ? sense_r[i] : sel_sense_s;
        end
    end

    // Recovery FSM next state and event strobes.
    always_comb begin
        state_s     = state_r;
        pulse_inc_s = 1'b0;
        set_fail_s  = 1'b0;
        set_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_s = ST_LOW;
                else         state_s = ST_IDLE;
            end
            ST_LOW: begin
                if (timer_last_s) begin
                    state_s     = ST_HIGH;
                    pulse_inc_s = 1'b1;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_HIGH: begin
                // pulse_r already includes the pulse that just completed.
                if (!timer_last_s) begin
                    state_s = ST_HIGH;
                end else if (sel_sense_s) begin
                    state_s = ST_STOP_LOW;
                end else if (pulse_r == 4'd9) begin
                    state_s    = ST_STOP_LOW;
                    set_fail_s = 1'b1;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_STOP_LOW: begin
                if (timer_last_s) state_s = ST_STOP_SETUP;
                else              state_s = ST_STOP_LOW;
            end
            ST_STOP_SETUP: begin
                if (timer_last_s) state_s = ST_STOP_HIGH;
                else              state_s = ST_STOP_SETUP;
            end
            ST_STOP_HIGH: begin
                if (timer_last_s) begin
                    state_s    = ST_IDLE;
                    set_done_s = 1'b1;
                end else begin
                    state_s = ST_STOP_HIGH;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state, phase timer, pulse count, channel latch and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            timer_r <= {TW{1'b0}};
            pulse_r <= 4'd0;
            chan_r  <= 3'd0;
            done_r  <= 1'b0;
            fail_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            if ((state_s != state_r) || (state_r == ST_IDLE)) timer_r <= {TW{1'b0}};
            else                                              timer_r <= timer_r + TW'(1'b1);
            if (start_s)          pulse_r <= 4'd0;
            else if (pulse_inc_s) pulse_r <= pulse_r + 4'd1;
            else                  pulse_r <= pulse_r;
            if (start_s) chan_r <= GPIO_OUT[2:0];
            else         chan_r <= chan_r;
            if (set_done_s)             done_r <= 1'b1;
            else if (start_s || clear_s) done_r <= 1'b0;
            else                        done_r <= done_r;
            if (set_fail_s)             fail_r <= 1'b1;
            else if (start_s || clear_s) fail_r <= 1'b0;
            else                        fail_r <= fail_r;
        end
    end

    // Pin values for the next cycle: recovery waveform on the selected channel,
    // handler passthrough elsewhere. Keyed on next state so pins and state align.
    always_comb begin
        chan_sel_s = start_s ? GPIO_OUT[2:0] : chan_r;
        case (state_s)
            ST_LOW:        begin rec_scl_s = 1'b0; rec_sda_s = 1'b1; end
            ST_HIGH:       begin rec_scl_s = 1'b1; rec_sda_s = 1'b1; end
            ST_STOP_LOW:   begin rec_scl_s = 1'b0; rec_sda_s = 1'b0; end
            ST_STOP_SETUP: begin rec_scl_s = 1'b1; rec_sda_s = 1'b0; end
            ST_STOP_HIGH:  begin rec_scl_s = 1'b1; rec_sda_s = 1'b1; end
            default:       begin rec_scl_s = 1'b1; rec_sda_s = 1'b1; end
        endcase
        scl_next_s = scl_in;
        sda_next_s = sda_drive_in;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if ((state_s != ST_IDLE) && (chan_sel_s == 3'(i))) begin
                scl_next_s[i] = rec_scl_s;
                sda_next_s[i] = rec_sda_s;
            end else begin
                scl_next_s[i] = scl_in[i];
                sda_next_s[i] = sda_drive_in[i];
            end
        end
    end

    // Registered pad drive; reset releases every pin at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_pin_r <= {CHANNEL_COUNT{1'b1}};
            sda_pin_r <= {CHANNEL_COUNT{1'b1}};
        end else begin
            scl_pin_r <= scl_next_s;
            sda_pin_r <= sda_next_s;
        end
    end

    // Zero-extend per-channel vectors into their status bytes.
    always_comb begin
        stuck_byte_s = 8'h00;
        sense_byte_s = 8'h00;
        stuck_byte_s[CHANNEL_COUNT-1:0] = stuck_r;
        sense_byte_s[CHANNEL_COUNT-1:0] = sense_r;
    end

    assign status        = {busy_r, fail_r, done_r, 1'b0, pulse_r, 1'b0, chan_r,
                            4'h0, stuck_byte_s, sense_byte_s};
    assign sda_sense_out = sense_r;
    assign scl_pin       = scl_pin_r;
    assign sda_pin       = sda_pin_r;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// -----------------------------------------------------------------------------
// tb_i2c_bus_conditioner
// Self-checking bench for i2c_bus_conditioner (HALF=10, FILTER_LEN=4,
// STUCK_CYCLES=200, 4 channels): reset state, table of passthrough/filter
// vectors, randomized idle traffic against a sample-history reference model,
// and hand-written sequences for glitch, stuck detect, recovery and reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_bus_conditioner;

    localparam int CH    = 4;
    localparam int HALF  = 10;
    localparam int FL    = 4;
    localparam int STUCK = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          csrStrobe;
    logic [31:0]   GPIO_OUT;
    logic [31:0]   status;
    logic [CH-1:0] scl_in, sda_drive_in, sda_sense_out, scl_pin, sda_pin, sda_pin_sense;

    int checks = 0;
    int errors = 0;

    i2c_bus_conditioner #(
        .CLK_RATE(2000000), .I2C_RATE(100000), .CHANNEL_COUNT(CH),
        .FILTER_LEN(FL), .STUCK_CYCLES(STUCK)
    ) dut (
        .clk(clk), .rst(rst), .csrStrobe(csrStrobe), .GPIO_OUT(GPIO_OUT),
        .status(status), .scl_in(scl_in), .sda_drive_in(sda_drive_in),
        .sda_sense_out(sda_sense_out), .scl_pin(scl_pin), .sda_pin(sda_pin),
        .sda_pin_sense(sda_pin_sense)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  scl, drv, pad;
        int          hold;
        logic [3:0]  e_scl, e_sda, e_sense;
        logic [31:0] e_status;
    } vec_t;

    vec_t       vecs [8];
    logic [1:0] wave [$];

    // reference model state for randomized traffic
    logic [15:0] m_hist [CH];
    logic [3:0]  m_sense, m_stuck;
    int          m_run [CH];
    int          run_left [CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [31:0] w);
        csrStrobe = 1'b1;
        GPIO_OUT  = w;
        tick();
        csrStrobe = 1'b0;
        GPIO_OUT  = 32'h0;
    endtask

    // Expected {scl,sda} per cycle of a recovery with the given pulse count.
    task automatic build_wave(input int pulses);
        wave.delete();
        for (int p = 0; p < pulses; p++) begin
            for (int k = 0; k < HALF; k++) wave.push_back(2'b01);
            for (int k = 0; k < HALF; k++) wave.push_back(2'b11);
        end
        for (int k = 0; k < HALF; k++) wave.push_back(2'b00);
        for (int k = 0; k < HALF; k++) wave.push_back(2'b10);
        for (int k = 0; k < HALF; k++) wave.push_back(2'b11);
    endtask

    // Start recovery on ch and compare its pins cycle by cycle; optional slave
    // holds SDA low until the third SCL rising edge.
    task automatic run_recovery(input int ch, input int pulses, input bit slave);
        int  rises;
        logic prev;
        rises = 0;
        prev  = 1'b1;
        build_wave(pulses);
        cmd(32'h8000_0000 | 32'(ch));
        for (int i = 0; i < wave.size(); i++) begin
            check($sformatf("wave_ch%0d_cyc%0d", ch, i), {30'h0, scl_pin[ch], sda_pin[ch]}, {30'h0, wave[i]});
            if (slave) begin
                if (!prev && scl_pin[ch]) rises++;
                prev = scl_pin[ch];
                sda_pin_sense[ch] = sda_pin[ch] & (rises >= 3);
            end
            tick();
        end
    endtask

    initial begin
        int lat;
        bit seen;
        logic [3:0] pad;

        vecs[0] = '{4'hF, 4'hF, 4'hF, 2, 4'hF, 4'hF, 4'hF, 32'h0000_000F};
        vecs[1] = '{4'hB, 4'hF, 4'hF, 1, 4'hB, 4'hF, 4'hF, 32'h0000_000F};
        vecs[2] = '{4'hF, 4'hF, 4'hF, 1, 4'hF, 4'hF, 4'hF, 32'h0000_000F};
        vecs[3] = '{4'hA, 4'h5, 4'hF, 1, 4'hA, 4'h5, 4'hF, 32'h0000_000F};
        vecs[4] = '{4'h5, 4'hA, 4'hE, 8, 4'h5, 4'hA, 4'hE, 32'h0000_000E};
        vecs[5] = '{4'h0, 4'h0, 4'h0, 8, 4'h0, 4'h0, 4'h0, 32'h0000_0000};
        vecs[6] = '{4'hF, 4'h3, 4'h6, 8, 4'hF, 4'h3, 4'h6, 32'h0000_0006};
        vecs[7] = '{4'hF, 4'hF, 4'hF, 8, 4'hF, 4'hF, 4'hF, 32'h0000_000F};

        rst = 1'b1; csrStrobe = 1'b0; GPIO_OUT = 32'h0;
        scl_in = 4'hF; sda_drive_in = 4'hF; sda_pin_sense = 4'hF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_pins", {24'h0, scl_pin, sda_pin}, 32'h0000_00FF);
        check("reset_status", status, 32'h0000_000F);

        // table-driven passthrough and filter vectors
        foreach (vecs[v]) begin
            scl_in = vecs[v].scl; sda_drive_in = vecs[v].drv; sda_pin_sense = vecs[v].pad;
            repeat (vecs[v].hold) tick();
            check($sformatf("vec%0d_pins", v), {20'h0, scl_pin, sda_pin, sda_sense_out},
                  {20'h0, vecs[v].e_scl, vecs[v].e_sda, vecs[v].e_sense});
            check($sformatf("vec%0d_status", v), status, vecs[v].e_status);
        end

        // randomized idle traffic against the history model
        m_sense = 4'hF; m_stuck = 4'h0; pad = 4'hF;
        for (int c = 0; c < CH; c++) begin
            m_hist[c] = 16'hFFFF; m_run[c] = 0; run_left[c] = $urandom_range(1, 8);
        end
        for (int n = 0; n < 300; n++) begin
            scl_in = 4'($urandom); sda_drive_in = 4'($urandom);
            for (int c = 0; c < CH; c++) begin
                run_left[c]--;
                if (run_left[c] == 0) begin
                    pad[c] = ~pad[c];
                    run_left[c] = $urandom_range(1, 8);
                end
            end
            sda_pin_sense = pad;
            tick();
            for (int c = 0; c < CH; c++) begin
                if (!m_sense[c] && scl_in[c]) m_run[c]++;
                else                          m_run[c] = 0;
                if (m_run[c] >= STUCK) m_stuck[c] = 1'b1;
                m_hist[c] = {m_hist[c][14:0], sda_pin_sense[c]};
                // level accepted once the last FL synchronised samples all disagree
                if (m_hist[c][2 +: FL] == {FL{~m_sense[c]}}) m_sense[c] = ~m_sense[c];
            end
            check($sformatf("rand%0d_pins", n), {20'h0, scl_pin, sda_pin, sda_sense_out},
                  {20'h0, scl_in, sda_drive_in, m_sense});
            check($sformatf("rand%0d_status", n), status, {16'h0, 4'h0, m_stuck, 4'h0, m_sense});
        end
        scl_in = 4'hF; sda_drive_in = 4'hF; sda_pin_sense = 4'hF;
        repeat (10) tick();
        cmd(32'h4000_0000);
        check("post_random_status", status, 32'h0000_000F);

        // 3-cycle glitch must not propagate
        seen = 1'b0;
        sda_pin_sense[0] = 1'b0;
        repeat (3) tick();
        sda_pin_sense[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (!sda_sense_out[0]) seen = 1'b1;
        end
        check("glitch_blocked", {31'h0, seen}, 32'h0);

        // 6-cycle low: output falls exactly 6 cycles after the pad edge
        lat = 0;
        sda_pin_sense[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 6) sda_pin_sense[0] = 1'b1;
            if (!sda_sense_out[0] && lat == 0) lat = k;
        end
        check("filter_latency", 32'(lat), 32'd6);
        repeat (8) tick();
        check("filter_recover", {28'h0, sda_sense_out}, 32'hF);

        // stuck detect: 200 + 6 cycles from the pad edge
        lat = 0;
        sda_pin_sense[1] = 1'b0;
        for (int k = 1; k <= 400 && lat == 0; k++) begin
            tick();
            if (status[9]) lat = k;
        end
        check("stuck_latency", 32'(lat), 32'd206);
        sda_pin_sense[1] = 1'b1;
        repeat (10) tick();
        cmd(32'h4000_0000);
        check("stuck_cleared", status, 32'h0000_000F);

        // SCL low at cycle 150 restarts the count
        lat = 0;
        sda_pin_sense[1] = 1'b0;
        for (int k = 1; k <= 500 && lat == 0; k++) begin
            if (k == 150) scl_in[1] = 1'b0;
            tick();
            scl_in[1] = 1'b1;
            if (status[9]) lat = k;
        end
        check("stuck_restart", 32'(lat), 32'd350);
        sda_pin_sense[1] = 1'b1;
        repeat (10) tick();
        cmd(32'h4000_0000);
        check("stuck_cleared2", status, 32'h0000_000F);

        // recovery on ch1, slave releases after third pulse
        sda_pin_sense[1] = 1'b0;
        repeat (8) tick();
        run_recovery(1, 3, 1'b1);
        check("rec_ch1_status", status, 32'h2310_000F);
        sda_pin_sense[1] = 1'b1;
        repeat (10) tick();

        // recovery on ch3 with SDA stuck forever
        scl_in[3] = 1'b0;
        sda_pin_sense[3] = 1'b0;
        repeat (8) tick();
        run_recovery(3, 9, 1'b0);
        check("rec_ch3_status", status, 32'h6930_0007);
        sda_pin_sense[3] = 1'b1;
        scl_in[3] = 1'b1;
        repeat (10) tick();

        // start on a nonexistent channel is dropped and clears nothing
        cmd(32'h8000_0005);
        check("bad_channel", status, 32'h6930_000F);
        cmd(32'h4000_0000);
        check("flag_clear", status, 32'h0930_000F);

        // second start while busy is ignored, then reset mid-LOW
        cmd(32'h8000_0002);
        check("start_ch2", status, 32'h8020_000F);
        repeat (2) tick();
        sda_drive_in[0] = 1'b0;
        cmd(32'h8000_0000);
        check("busy_start_status", status, 32'h8020_000F);
        check("busy_start_pins", {24'h0, scl_pin, sda_pin}, {24'h0, 4'b1011, 4'b1110});
        rst = 1'b1;
        #1;
        check("rst_pins", {24'h0, scl_pin, sda_pin}, 32'h0000_00FF);
        check("rst_status", status, 32'h0000_000F);
        tick();
        rst = 1'b0;
        sda_drive_in[0] = 1'b1;
        repeat (3) tick();
        check("post_rst", {scl_pin, sda_pin, status[23:0]}, {8'hFF, 24'h00_000F});
        check("post_rst_busy", {24'h0, status[31:24]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
